// File: rtl/ram_pkg.sv
// Shared geometry and word/address types for the 256x8 simple dual-port RAM.
package ram_pkg;

  localparam int unsigned RAM_DATA_WIDTH = 8;
  localparam int unsigned RAM_ADDR_WIDTH = 8;
  localparam int unsigned RAM_DEPTH      = 256;

  typedef logic [RAM_DATA_WIDTH-1:0] ram_word_t;
  typedef logic [RAM_ADDR_WIDTH-1:0] ram_addr_t;

endpackage : ram_pkg

// File: rtl/ram_read_reg.sv
// Read-enable-gated output register with asynchronous clear.
module ram_read_reg #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  // Hold the last read value while the port is idle
  always_comb begin
    q_d = q_q;
    if (en_i) q_d = d_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q_q <= '0;
    else        q_q <= q_d;
  end

  assign q_o = q_q;

endmodule : ram_read_reg

// File: rtl/dual_port_ram_256x8.sv
// Simple dual-port synchronous RAM: one write port, one registered read port,
// read-before-write on same-address collision, full clear on reset.
module dual_port_ram_256x8
  import ram_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = RAM_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = RAM_ADDR_WIDTH,
  parameter int unsigned DEPTH      = RAM_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  we,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] data_out
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];
  logic [DATA_WIDTH-1:0] rd_data_c;

  always_comb begin
    mem_d = mem_q;
    if (we) mem_d[wr_addr] = data_in;
  end

  // Storage is flop-based so reset can clear every word asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  // Reads the pre-edge contents, giving read-before-write on collisions
  assign rd_data_c = mem_q[rd_addr];

  ram_read_reg #(
    .WIDTH (DATA_WIDTH)
  ) u_read_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .en_i  (re),
    .d_i   (rd_data_c),
    .q_o   (data_out)
  );

endmodule : dual_port_ram_256x8

// File: tb/tb_dual_port_ram_256x8.sv
// Directed self-checking bench for dual_port_ram_256x8.
module tb_dual_port_ram_256x8;
  import ram_pkg::*;

  logic      clk;
  logic      rst_n;
  ram_word_t data_in;
  logic      we;
  logic      re;
  ram_addr_t wr_addr;
  ram_addr_t rd_addr;
  ram_word_t data_out;

  int checks;
  int errors;

  dual_port_ram_256x8 dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .data_in  (data_in),
    .we       (we),
    .re       (re),
    .wr_addr  (wr_addr),
    .rd_addr  (rd_addr),
    .data_out (data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors %0d", errors);
    $fatal(1, "watchdog expired");
  end

  // Advance past the next rising edge; inputs change and outputs are sampled here
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we = 1'b0; re = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; we = 1'b0; re = 1'b0;
    data_in = '0; wr_addr = '0; rd_addr = '0;
    #3;
    checks++;
    if (data_out !== 8'h00) begin
      errors++;
      $display("FAIL reset_data_out: got %h expected 00", data_out);
    end
    cycle();
    rst_n = 1'b1;
    cycle();
  endtask

  task automatic test_write_read();
    for (int i = 0; i < 5; i++) begin
      we = 1'b1; wr_addr = 8'(i); data_in = 8'(i + 1);
      cycle();
    end
    we = 1'b0;
    for (int i = 0; i < 5; i++) begin
      re = 1'b1; rd_addr = 8'(i);
      cycle();
      checks++;
      if (data_out !== 8'(i + 1)) begin
        errors++;
        $display("FAIL write_read addr %0d: got %h expected %h", i, data_out, 8'(i + 1));
      end
    end
    idle();
  endtask

  task automatic test_hold();
    for (int i = 0; i < 3; i++) begin
      we = 1'b1; re = 1'b0; wr_addr = 8'(5 + i); data_in = 8'(6 + i);
      rd_addr = 8'(5 + i);
      cycle();
      checks++;
      if (data_out !== 8'h05) begin
        errors++;
        $display("FAIL hold cycle %0d: got %h expected 05", i, data_out);
      end
    end
    we = 1'b0;
    for (int i = 0; i < 3; i++) begin
      re = 1'b1; rd_addr = 8'(5 + i);
      cycle();
      checks++;
      if (data_out !== 8'(6 + i)) begin
        errors++;
        $display("FAIL hold_read addr %0d: got %h expected %h", 5 + i, data_out, 8'(6 + i));
      end
    end
    idle();
  endtask

  task automatic test_collision();
    we = 1'b1; wr_addr = 8'd10; data_in = 8'hAA;
    cycle();
    we = 1'b1; wr_addr = 8'd10; data_in = 8'h55;
    re = 1'b1; rd_addr = 8'd10;
    cycle();
    checks++;
    if (data_out !== 8'hAA) begin
      errors++;
      $display("FAIL collision_old: got %h expected aa", data_out);
    end
    we = 1'b0;
    cycle();
    checks++;
    if (data_out !== 8'h55) begin
      errors++;
      $display("FAIL collision_new: got %h expected 55", data_out);
    end
    idle();
  endtask

  task automatic test_boundary();
    we = 1'b1; wr_addr = 8'd255; data_in = 8'hFF;
    cycle();
    wr_addr = 8'd0; data_in = 8'h11;
    cycle();
    we = 1'b0; re = 1'b1; rd_addr = 8'd255;
    cycle();
    checks++;
    if (data_out !== 8'hFF) begin
      errors++;
      $display("FAIL boundary_255: got %h expected ff", data_out);
    end
    rd_addr = 8'd0;
    cycle();
    checks++;
    if (data_out !== 8'h11) begin
      errors++;
      $display("FAIL boundary_0: got %h expected 11", data_out);
    end
    rd_addr = 8'd200;
    cycle();
    checks++;
    if (data_out !== 8'h00) begin
      errors++;
      $display("FAIL unwritten_200: got %h expected 00", data_out);
    end
    idle();
  endtask

  task automatic test_mid_reset();
    re = 1'b1; rd_addr = 8'd4;
    cycle();
    checks++;
    if (data_out !== 8'h05) begin
      errors++;
      $display("FAIL pre_reset_read: got %h expected 05", data_out);
    end
    re = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (data_out !== 8'h00) begin
      errors++;
      $display("FAIL async_reset: got %h expected 00", data_out);
    end
    // Writes attempted while reset is held must be ignored
    we = 1'b1; wr_addr = 8'd3; data_in = 8'h77;
    cycle();
    we = 1'b0;
    #2;
    rst_n = 1'b1;
    cycle();
    for (int i = 0; i < 5; i++) begin
      re = 1'b1; rd_addr = 8'(i);
      cycle();
      checks++;
      if (data_out !== 8'h00) begin
        errors++;
        $display("FAIL post_reset addr %0d: got %h expected 00", i, data_out);
      end
    end
    rd_addr = 8'd255;
    cycle();
    checks++;
    if (data_out !== 8'h00) begin
      errors++;
      $display("FAIL post_reset addr 255: got %h expected 00", data_out);
    end
    idle();
  endtask

  task automatic test_concurrent();
    for (int i = 0; i < 8; i++) begin
      we = 1'b1; wr_addr = 8'(8'h20 + i); data_in = 8'(8'h40 + i);
      re = (i > 0); rd_addr = 8'(8'h20 + i - 1);
      cycle();
      if (i > 0) begin
        checks++;
        if (data_out !== 8'(8'h40 + i - 1)) begin
          errors++;
          $display("FAIL concurrent step %0d: got %h expected %h", i, data_out, 8'(8'h40 + i - 1));
        end
      end
    end
    we = 1'b0;
    for (int i = 0; i < 8; i++) begin
      re = 1'b1; rd_addr = 8'(8'h20 + i);
      cycle();
      checks++;
      if (data_out !== 8'(8'h40 + i)) begin
        errors++;
        $display("FAIL concurrent_readback addr %h: got %h expected %h", 8'(8'h20 + i), data_out, 8'(8'h40 + i));
      end
    end
    rd_addr = 8'h28;
    cycle();
    checks++;
    if (data_out !== 8'h00) begin
      errors++;
      $display("FAIL concurrent_neighbour 28: got %h expected 00", data_out);
    end
    rd_addr = 8'h1F;
    cycle();
    checks++;
    if (data_out !== 8'h00) begin
      errors++;
      $display("FAIL concurrent_neighbour 1f: got %h expected 00", data_out);
    end
    idle();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_write_read();
    test_hold();
    test_collision();
    test_boundary();
    test_mid_reset();
    test_concurrent();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_dual_port_ram_256x8
